// File: rtl/mul_cpa_stage.sv
// mul_cpa_stage: two-stage split carry-propagate adder resolving the Wallace sum/carry pair into a 32-bit product word
module mul_cpa_stage #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*XLEN:0]   in_sum,
    input  logic [2*XLEN:0]   in_carry,
    input  logic              in_hi,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAGW-1:0]   out_tag,
    output logic              busy
);
    logic            s1_valid, s1_c32, s1_hi;
    logic [XLEN-1:0] s1_lo, s1_sum_hi, s1_carry_hi;
    logic [TAGW-1:0] s1_tag;
    logic            s2_valid;
    logic [XLEN-1:0] s2_result;
    logic [TAGW-1:0] s2_tag;
    logic            s2_free, s1_adv, in_fire;
    logic [XLEN:0]   lo_sum;
    logic [XLEN-1:0] hi_word;

    // handshake steering and the two per-stage adders
    always_comb begin
        s2_free  = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_free;
        in_ready = !s1_valid || s1_adv;
        in_fire  = in_valid && in_ready;
        lo_sum   = {1'b0, in_sum[XLEN-1:0]} + {1'b0, in_carry[XLEN-1:0]};
        hi_word  = s1_sum_hi + s1_carry_hi + {{(XLEN-1){1'b0}}, s1_c32};
    end

    // valid bits; reset and flush kill every in-flight entry
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s1_adv);
            s2_valid <= s1_adv || (s2_valid && !out_ready);
        end
    end

    // stage 1 data: low word resolved, high halves carried forward untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_lo       <= '0;
            s1_c32      <= 1'b0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_hi       <= 1'b0;
            s1_tag      <= '0;
        end else if (in_fire) begin
            s1_lo       <= lo_sum[XLEN-1:0];
            s1_c32      <= lo_sum[XLEN];
            s1_sum_hi   <= in_sum[2*XLEN-1:XLEN];
            s1_carry_hi <= in_carry[2*XLEN-1:XLEN];
            s1_hi       <= in_hi;
            s1_tag      <= in_tag;
        end
    end

    // stage 2 data: high word resolved and the requested word selected
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (s1_adv) begin
            s2_result <= s1_hi ? hi_word : s1_lo;
            s2_tag    <= s1_tag;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;
    assign busy       = s1_valid || s2_valid;
endmodule

// File: tb/tb_mul_cpa_stage.sv
// tb_mul_cpa_stage: directed and streaming checks of the carry-propagate back end
module tb_mul_cpa_stage;
    typedef struct {
        logic [64:0] s;
        logic [64:0] c;
        logic        h;
        logic [4:0]  t;
    } vec_t;
    typedef struct {
        logic [31:0] r;
        logic [4:0]  t;
    } exp_t;

    logic        clk = 0;
    logic        rst, flush, in_valid, in_ready, in_hi, out_valid, out_ready, busy;
    logic [64:0] in_sum, in_carry;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_result;

    int checks = 0;
    int errors = 0;
    int n_in, n_out, cyc;
    vec_t stim[$];
    exp_t exp_q[$];

    mul_cpa_stage #(.XLEN(32), .TAGW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_hi(in_hi), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] gold(input vec_t v);
        logic [64:0] p;
        p = v.s + v.c;
        return v.h ? p[63:32] : p[31:0];
    endfunction

    function automatic vec_t mk(input logic [64:0] s, input logic [64:0] c, input logic h, input logic [4:0] t);
        vec_t v;
        v.s = s; v.c = c; v.h = h; v.t = t;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step_cycle(input logic rdy);
        exp_t e;
        out_ready = rdy;
        in_valid  = stim.size() > 0;
        if (in_valid) begin
            in_sum = stim[0].s; in_carry = stim[0].c; in_hi = stim[0].h; in_tag = stim[0].t;
        end
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_output", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("stream_result", out_result, e.r);
                check("stream_tag", out_tag, e.t);
            end
            n_out++;
        end
        if (in_valid && in_ready) begin
            e.r = gold(stim[0]);
            e.t = stim[0].t;
            exp_q.push_back(e);
            void'(stim.pop_front());
            n_in++;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic send(input string name, input vec_t v, input logic [31:0] want);
        out_ready = 1;
        in_valid = 1; in_sum = v.s; in_carry = v.c; in_hi = v.h; in_tag = v.t;
        #1;
        check({name, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 0;
        check({name, "_latency"}, out_valid, 0);
        tick();
        check({name, "_valid"}, out_valid, 1);
        check({name, "_result"}, out_result, want);
        check({name, "_tag"}, out_tag, v.t);
        tick();
        check({name, "_drained"}, busy, 0);
    endtask

    task automatic load_two;
        stim.push_back(mk(65'd10, 65'd1, 1'b0, 5'd7));
        stim.push_back(mk(65'd20, 65'd2, 1'b0, 5'd8));
        step_cycle(0);
        step_cycle(0);
        exp_q.delete();
        check("two_in_flight", busy, 1);
    endtask

    initial begin
        logic [95:0] r1, r2;
        logic        gap;
        rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_hi = 0; in_tag = 0;
        in_sum = 0; in_carry = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        tick();

        send("basic_lo", mk(65'h3, 65'h4, 1'b0, 5'd5), 32'h00000007);
        send("carry_hi", mk(65'h0_0000_0000_FFFF_FFFF, 65'h1, 1'b1, 5'd9), 32'h00000001);
        send("carry_lo", mk(65'h0_0000_0000_FFFF_FFFF, 65'h1, 1'b0, 5'd10), 32'h00000000);
        send("neg_hi", mk(65'h1_FFFF_FFFF_FFFF_FFFA, 65'h0, 1'b1, 5'd11), 32'hFFFFFFFF);
        send("neg_lo", mk(65'h1_FFFF_FFFF_FFFF_FFFA, 65'h0, 1'b0, 5'd12), 32'hFFFFFFFA);
        send("bit64_drop", mk(65'h1_8000_0000_0000_0000, 65'h1_8000_0000_0000_0000, 1'b1, 5'd13), 32'h00000000);

        // backpressure: four inputs, tags 1..4, result = 2*tag
        n_in = 0; n_out = 0;
        for (int i = 1; i <= 4; i++) stim.push_back(mk(65'(i), 65'(i), 1'b0, 5'(i)));
        for (int i = 0; i < 6; i++) begin
            step_cycle(0);
            if (i >= 1) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_hold_tag", out_tag, 1);
                check("stall_hold_result", out_result, 2);
            end
            if (i >= 1) check("stall_in_ready", in_ready, 0);
        end
        check("stall_accepts", n_in, 2);
        out_ready = 1;
        #1;
        check("release_in_ready", in_ready, 1);
        cyc = 0;
        while ((stim.size() > 0 || exp_q.size() > 0) && cyc < 20) begin
            step_cycle(1);
            cyc++;
        end
        check("bp_outputs", n_out, 4);
        check("bp_drain_budget", cyc < 20, 1);
        check("bp_empty", busy, 0);

        // full throughput: 100 random back-to-back inputs
        n_in = 0; n_out = 0; cyc = 0; gap = 0;
        for (int i = 0; i < 100; i++) begin
            r1 = {$urandom(), $urandom(), $urandom()};
            r2 = {$urandom(), $urandom(), $urandom()};
            stim.push_back(mk(r1[64:0], r2[64:0], 1'($urandom_range(0, 1)), 5'(i)));
        end
        while ((stim.size() > 0 || exp_q.size() > 0) && cyc < 300) begin
            if (stim.size() > 0 && !in_ready) gap = 1;
            if (cyc >= 2 && n_out < 100 && !out_valid) gap = 1;
            step_cycle(1);
            cyc++;
        end
        check("thru_outputs", n_out, 100);
        check("thru_cycles", cyc, 102);
        check("thru_no_bubble", gap, 0);

        // flush with two in flight and an input offered in the same cycle
        load_two();
        out_ready = 1; flush = 1; in_valid = 1;
        in_sum = 65'd99; in_carry = 0; in_hi = 0; in_tag = 5'd31;
        #1;
        check("flush_in_ready", in_ready, 1);
        tick();
        flush = 0; in_valid = 0;
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_emerge", out_valid, 0);
        end

        // reset with two in flight
        load_two();
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_out_result", out_result, 0);
        check("rst2_out_tag", out_tag, 0);

        // reset together with an offered input
        rst = 1; in_valid = 1; in_sum = 65'd5; in_carry = 65'd5; in_tag = 5'd3;
        tick();
        rst = 0; in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_dropped", out_valid || busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
